// File: rtl/dispatcher_pkg.sv
// rtl/dispatcher_pkg.sv - shared state encodings and response byte constants for cmd_dispatcher
//
// Contents:
//   disp_state_t  top-level dispatcher states
//   snd_state_t   single-byte sender handshake states
//   RESP_*        fixed response bytes sent back over the UART
package dispatcher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACK_TX,
        NAK_TX,
        RUN,
        RESP_TX
    } disp_state_t;

    typedef enum logic {
        SND_IDLE,
        SND_WAIT_DONE
    } snd_state_t;

    localparam logic [7:0] RESP_ACK     = 8'h06;
    localparam logic [7:0] RESP_NAK     = 8'h15;
    localparam logic [7:0] RESP_TIMEOUT = 8'h18;

    // Index width for a table of n entries; a one-entry table still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/resp_sender.sv
// rtl/resp_sender.sv - single-byte UART tx handshake shared by every response state
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   req        level request: a byte is waiting to be sent
//   tx_byte    byte to send, sampled when tx_start is issued
//   tx_active  uart_tx busy; the byte is held back while this is high
//   tx_done    one-cycle strobe from uart_tx when the byte has gone out
//   tx_start   one-cycle strobe towards uart_tx
//   tx_data    byte presented to uart_tx, held until the next tx_start
//   busy       a byte has been launched and its tx_done is outstanding
//   sent       combinational: the launched byte completes this cycle
module resp_sender
    import dispatcher_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [7:0] tx_byte,
    input  logic       tx_active,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       sent
);

    snd_state_t state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= SND_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                SND_IDLE: begin
                    if (req && !tx_active) begin
                        tx_start <= 1'b1;
                        tx_data  <= tx_byte;
                        state    <= SND_WAIT_DONE;
                    end
                end
                SND_WAIT_DONE: begin
                    // Returning to idle on the same edge the owner sees 'sent'
                    // keeps a still-high req from relaunching the byte.
                    if (tx_done) begin
                        state <= SND_IDLE;
                    end
                end
                default: state <= SND_IDLE;
            endcase
        end
    end

    assign busy = (state == SND_WAIT_DONE);
    assign sent = busy && tx_done;

endmodule

// File: rtl/cmd_dispatcher.sv
// rtl/cmd_dispatcher.sv - UART command decoder that runs one channel at a time and reports the outcome
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-low reset
//   rx_ready    one-cycle strobe: rx_data valid
//   rx_data     received byte
//   tx_active   uart_tx busy
//   tx_done     one-cycle strobe: byte transmission finished
//   tx_start    one-cycle strobe: send tx_data
//   tx_data     response byte, stable from tx_start until tx_done
//   activate    one-hot (or zero) channel enable, held while the channel runs
//   ch_done     channel completion, only the active channel's bit is looked at
//   status      code of the command in progress, 8'h00 when idle
//   rx_dropped  sticky: a byte arrived while a response was pending
module cmd_dispatcher
    import dispatcher_pkg::*;
#(
    parameter int                    N_CH           = 4,
    parameter logic [N_CH-1:0][7:0]  CMD_CODES      = {8'h71, 8'h22, 8'h21, 8'h11},
    parameter int unsigned           TIMEOUT_CYCLES = 32'd50_000_000,
    parameter int                    TO_W           = 26
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_ready,
    input  logic [7:0]      rx_data,
    input  logic            tx_active,
    input  logic            tx_done,
    output logic            tx_start,
    output logic [7:0]      tx_data,
    output logic [N_CH-1:0] activate,
    input  logic [N_CH-1:0] ch_done,
    output logic [7:0]      status,
    output logic            rx_dropped
);

    localparam int              IDX_W   = idx_width(N_CH);
    localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

    disp_state_t      state;
    logic [N_CH-1:0]  sel_onehot;
    logic [7:0]       cmd_code;
    logic [7:0]       resp_byte;
    logic [TO_W-1:0]  timer;

    // Code table compare, one comparator per channel.
    logic [N_CH-1:0] code_hit;
    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_cmp
            assign code_hit[g] = (rx_data == CMD_CODES[g]);
        end
    endgenerate

    // Priority encoder: scanning from the top down lets the lowest matching
    // channel overwrite any higher one when codes are duplicated.
    logic [IDX_W-1:0] hit_idx;
    logic             any_hit;
    always_comb begin
        hit_idx = '0;
        any_hit = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (code_hit[i]) begin
                hit_idx = IDX_W'(i);
                any_hit = 1'b1;
            end
        end
    end

    logic [N_CH-1:0] hit_onehot;
    assign hit_onehot = N_CH'(1) << hit_idx;

    logic sel_done;
    assign sel_done = |(ch_done & sel_onehot);

    logic timed_out;
    assign timed_out = TO_EN && (timer == TO_LAST);

    // Byte offered to the sender in each of the three response states.
    logic       snd_req;
    logic [7:0] snd_byte;
    logic       snd_busy;
    logic       snd_sent;
    always_comb begin
        snd_req  = 1'b0;
        snd_byte = RESP_ACK;
        case (state)
            ACK_TX:  begin snd_req = 1'b1; snd_byte = RESP_ACK;  end
            NAK_TX:  begin snd_req = 1'b1; snd_byte = RESP_NAK;  end
            RESP_TX: begin snd_req = 1'b1; snd_byte = resp_byte; end
            default: ;
        endcase
    end

    resp_sender u_sender (
        .clk       (clk),
        .reset     (reset),
        .req       (snd_req),
        .tx_byte   (snd_byte),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .busy      (snd_busy),
        .sent      (snd_sent)
    );

    // The sender only ever holds a byte on behalf of a response state.
    assert property (@(posedge clk) disable iff (!reset) snd_busy |-> snd_req);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            sel_onehot <= '0;
            cmd_code   <= '0;
            resp_byte  <= '0;
            timer      <= '0;
            activate   <= '0;
            status     <= '0;
            rx_dropped <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_ready) begin
                        if (any_hit) begin
                            sel_onehot <= hit_onehot;
                            cmd_code   <= rx_data;
                            status     <= rx_data;
                            rx_dropped <= 1'b0;
                            state      <= ACK_TX;
                        end else begin
                            state <= NAK_TX;
                        end
                    end
                end
                ACK_TX: begin
                    if (rx_ready) rx_dropped <= 1'b1;
                    if (snd_sent) begin
                        activate <= sel_onehot;
                        timer    <= '0;
                        state    <= RUN;
                    end
                end
                NAK_TX: begin
                    if (rx_ready) rx_dropped <= 1'b1;
                    if (snd_sent) state <= IDLE;
                end
                RUN: begin
                    // Bytes arriving here belong to the running channel.
                    timer <= timer + TO_W'(1);
                    if (sel_done) begin
                        activate  <= '0;
                        resp_byte <= cmd_code;
                        state     <= RESP_TX;
                    end else if (timed_out) begin
                        activate  <= '0;
                        resp_byte <= RESP_TIMEOUT;
                        state     <= RESP_TX;
                    end
                end
                RESP_TX: begin
                    if (rx_ready) rx_dropped <= 1'b1;
                    if (snd_sent) begin
                        status <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb/tb_cmd_dispatcher.sv - self-checking bench for cmd_dispatcher with a behavioural reference model
module tb_cmd_dispatcher;

    localparam int N_CH = 4;
    localparam int TO   = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_active;
    logic       tx_done = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [3:0] activate;
    logic [3:0] ch_done = 4'b0000;
    logic [7:0] status;
    logic       rx_dropped;

    logic uart_busy = 1'b0;
    logic ext_busy  = 1'b0;
    assign tx_active = uart_busy | ext_busy;

    always #5 clk = ~clk;

    cmd_dispatcher #(
        .N_CH           (N_CH),
        .CMD_CODES      ({8'h71, 8'h22, 8'h21, 8'h11}),
        .TIMEOUT_CYCLES (TO),
        .TO_W           (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .tx_active  (tx_active),
        .tx_done    (tx_done),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .activate   (activate),
        .ch_done    (ch_done),
        .status     (status),
        .rx_dropped (rx_dropped)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] code_tab [N_CH] = '{8'h11, 8'h21, 8'h22, 8'h71};

    function automatic int lookup(input logic [7:0] b);
        for (int i = 0; i < N_CH; i++) if (code_tab[i] == b) return i;
        return -1;
    endfunction

    typedef enum int {M_IDLE, M_SEND, M_RUN} mphase_t;
    mphase_t    m_phase = M_IDLE;
    int         m_ch = 0;
    int         m_cnt = 0;
    logic [7:0] m_code = 8'h00;
    logic [7:0] m_pend = 8'h00;
    bit         m_launched = 1'b0;
    bit         m_to_run = 1'b0;
    logic [3:0] e_act = 4'h0;
    logic [7:0] e_status = 8'h00;
    logic [7:0] e_data = 8'h00;
    bit         e_start = 1'b0;
    bit         e_drop = 1'b0;

    always @(posedge clk) begin
        e_start <= 1'b0;
        if (!reset) begin
            m_phase <= M_IDLE; m_launched <= 1'b0;
            e_act <= 4'h0; e_status <= 8'h00; e_data <= 8'h00; e_drop <= 1'b0;
        end else begin
            case (m_phase)
                M_IDLE: if (rx_ready) begin
                    m_launched <= 1'b0;
                    m_phase    <= M_SEND;
                    if (lookup(rx_data) >= 0) begin
                        m_ch <= lookup(rx_data); m_code <= rx_data; e_status <= rx_data;
                        e_drop <= 1'b0; m_pend <= 8'h06; m_to_run <= 1'b1;
                    end else begin
                        m_pend <= 8'h15; m_to_run <= 1'b0;
                    end
                end
                M_SEND: begin
                    if (rx_ready) e_drop <= 1'b1;
                    if (!m_launched) begin
                        if (!tx_active) begin
                            e_start <= 1'b1; e_data <= m_pend; m_launched <= 1'b1;
                        end
                    end else if (tx_done) begin
                        m_launched <= 1'b0;
                        if (m_to_run) begin
                            m_phase <= M_RUN; e_act <= 4'(1) << m_ch; m_cnt <= 0;
                        end else begin
                            m_phase <= M_IDLE; e_status <= 8'h00;
                        end
                    end
                end
                M_RUN: begin
                    if (ch_done[m_ch]) begin
                        e_act <= 4'h0; m_pend <= m_code; m_to_run <= 1'b0; m_phase <= M_SEND;
                    end else if (m_cnt == TO - 1) begin
                        e_act <= 4'h0; m_pend <= 8'h18; m_to_run <= 1'b0; m_phase <= M_SEND;
                    end
                    m_cnt <= m_cnt + 1;
                end
                default: m_phase <= M_IDLE;
            endcase
        end
    end

    // ---------------- compare + tx capture ----------------
    logic [7:0] cap [$];
    int         cap_cyc [$];
    bit         prev_start = 1'b0;

    always @(negedge clk) begin
        check("tx_start", tx_start, e_start);
        check("tx_data", tx_data, e_data);
        check("activate", activate, e_act);
        check("status", status, e_status);
        check("rx_dropped", rx_dropped, e_drop);
        check("act_onehot", ($countones(activate) <= 1), 1);
        if (tx_start === 1'b1) begin
            check("tx_start_gap", prev_start, 0);
            cap.push_back(tx_data);
            cap_cyc.push_back(cyc);
        end
        prev_start = (tx_start === 1'b1);
    end

    function automatic logic [7:0] cap_at(input int i);
        return (i < cap.size()) ? cap[i] : 8'hxx;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < cap_cyc.size()) ? cap_cyc[i] : -1000;
    endfunction

    // ---------------- uart_tx responder ----------------
    initial begin
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (tx_start === 1'b1) begin
                uart_busy = 1'b1;
                repeat ($urandom_range(1, 8)) @(negedge clk);
                tx_done   = 1'b1;
                uart_busy = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    int rx_cyc = 0;

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_ready = 1'b1; rx_data = b; rx_cyc = cyc;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic wait_phase(input mphase_t p, input int budget, input string nm);
        int n = 0;
        while (m_phase != p && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (m_phase != p) begin
            errors++;
            $display("FAIL %s: wait expired after %0d cycles", nm, n);
        end
    endtask

    task automatic pulse_done(input logic [3:0] m);
        @(negedge clk);
        ch_done = m;
        @(negedge clk);
        ch_done = 4'b0000;
    endtask

    initial begin
        int base, n, done_cyc;
        logic [7:0] b;

        repeat (2) @(negedge clk);
        check("rst_activate", activate, 4'h0);
        check("rst_status", status, 8'h00);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_rx_dropped", rx_dropped, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 1: normal command with echo
        base = cap.size();
        send_rx(8'h21);
        wait_phase(M_RUN, 100, "t1_run");
        check("t1_activate", activate, 4'b0010);
        check("t1_status", status, 8'h21);
        repeat (99) @(negedge clk);
        check("t1_activate_held", activate, 4'b0010);
        ch_done = 4'b0010; done_cyc = cyc;
        @(negedge clk);
        ch_done = 4'b0000;
        check("t1_activate_drop", activate, 4'b0000);
        wait_phase(M_IDLE, 100, "t1_idle");
        check("t1_ack", cap_at(base), 8'h06);
        check("t1_echo", cap_at(base + 1), 8'h21);
        check("t1_ack_latency", cyc_at(base) - rx_cyc, 2);
        check("t1_resp_latency", cyc_at(base + 1) - done_cyc, 2);
        check("t1_status_clear", status, 8'h00);

        // 2: unknown code
        base = cap.size();
        send_rx(8'h55);
        wait_phase(M_IDLE, 100, "t2_idle");
        check("t2_ntx", cap.size() - base, 1);
        check("t2_nak", cap_at(base), 8'h15);
        check("t2_status", status, 8'h00);

        // 3: timeout
        base = cap.size();
        send_rx(8'h11);
        wait_phase(M_RUN, 100, "t3_run");
        n = 0;
        while (activate !== 4'b0000 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check("t3_run_len", n, TO);
        wait_phase(M_IDLE, 100, "t3_idle");
        check("t3_timeout_byte", cap_at(base + 1), 8'h18);

        // 4: inactive ch_done ignored; done beats simultaneous timeout
        base = cap.size();
        send_rx(8'h22);
        wait_phase(M_RUN, 100, "t4_run");
        ch_done = 4'b1011;
        @(negedge clk);
        ch_done = 4'b0000;
        check("t4_inactive_ignored", activate, 4'b0100);
        n = 0;
        while (m_cnt != TO - 1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        ch_done = 4'b0100;
        @(negedge clk);
        ch_done = 4'b0000;
        wait_phase(M_IDLE, 100, "t4_idle");
        check("t4_done_wins", cap_at(base + 1), 8'h22);

        // 5: byte during stalled ACK is dropped
        base = cap.size();
        ext_busy = 1'b1;
        send_rx(8'h71);
        repeat (2) @(negedge clk);
        send_rx(8'h71);
        check("t5_dropped", rx_dropped, 1'b1);
        check("t5_ack_held", cap.size() - base, 0);
        repeat (3) @(negedge clk);
        ext_busy = 1'b0;
        wait_phase(M_RUN, 100, "t5_run");
        pulse_done(4'b1000);
        wait_phase(M_IDLE, 100, "t5_idle");
        check("t5_ntx", cap.size() - base, 2);
        check("t5_ack", cap_at(base), 8'h06);
        check("t5_echo", cap_at(base + 1), 8'h71);
        check("t5_sticky", rx_dropped, 1'b1);
        send_rx(8'h21);
        check("t5_cleared", rx_dropped, 1'b0);
        wait_phase(M_RUN, 100, "t5b_run");
        pulse_done(4'b0010);
        wait_phase(M_IDLE, 100, "t5b_idle");

        // 6: reset during RUN
        base = cap.size();
        send_rx(8'h22);
        wait_phase(M_RUN, 100, "t6_run");
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t6_activate", activate, 4'h0);
        check("t6_status", status, 8'h00);
        check("t6_tx_start", tx_start, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_no_resp", cap.size() - base, 1);
        base = cap.size();
        send_rx(8'h22);
        wait_phase(M_RUN, 100, "t6b_run");
        check("t6_ack", cap_at(base), 8'h06);
        pulse_done(4'b0100);
        wait_phase(M_IDLE, 100, "t6b_idle");
        check("t6_echo", cap_at(base + 1), 8'h22);

        // randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0, 1:    b = code_tab[$urandom_range(0, N_CH - 1)];
                2:       b = 8'($urandom_range(0, 255));
                default: b = 8'h00;
            endcase
            send_rx(b);
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                rx_ready = (m_phase != M_IDLE) && ($urandom_range(0, 7) == 0);
                rx_data  = 8'($urandom_range(0, 255));
                ch_done  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            end
            @(negedge clk);
            rx_ready = 1'b0;
            ch_done  = (m_phase == M_RUN) ? 4'hF : 4'h0;
            @(negedge clk);
            ch_done = 4'h0;
            wait_phase(M_IDLE, 3000, "rnd_idle");
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
